// File: rtl/xor5_pkg.sv
// Shared definitions for the xor5 frame checker: symbol width, FSM states
// and the saturating increment used by the error counters.
package xor5_pkg;

  localparam int SYM_W = 5;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  // Counters are passed zero-extended to 32 bits together with their all-ones
  // ceiling, so one function serves every counter width up to 31 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/parity5.sv
// Purely combinational 5-input XOR producing the computed parity of a symbol.
module parity5
  import xor5_pkg::*;
(
  input  logic [SYM_W-1:0] data,
  output logic             par
);

  // Reduction XOR over all symbol bits.
  assign par = ^data;

endmodule

// File: rtl/xor5_frame_checker.sv
// Frame checker: accepts 5-bit symbols with a transmitted parity bit, counts
// parity mismatches per frame and since reset, and hands one summary per frame
// to the consumer through a valid/ready handshake.
module xor5_frame_checker
  import xor5_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic             out_frame_par,
  output logic             out_len_err,
  output logic [CNT_W-1:0] tot_err_cnt
);

  // All-ones ceiling of the error counters, in the 32-bit form sat_inc expects.
  localparam logic [31:0] CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
  // FRAME_LEN is at most 255, so an 8-bit symbol counter always suffices.
  localparam logic [7:0]  LEN_FULL = 8'(FRAME_LEN);

  state_t           state_q, state_d;
  logic             frame_par_q, frame_par_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] tot_err_q, tot_err_d;
  logic [CNT_W-1:0] out_err_cnt_q, out_err_cnt_d;
  logic             out_frame_par_q, out_frame_par_d;
  logic             out_len_err_q, out_len_err_d;

  logic             sym_par;
  logic             accept;
  logic             mismatch;
  logic [7:0]       sym_next;
  logic             at_len;
  logic             close;
  logic             par_acc;
  logic [CNT_W-1:0] err_acc;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] tot_inc;

  parity5 u_parity5 (
    .data (in_data),
    .par  (sym_par)
  );

  // Per-symbol decode: accept strobe, mismatch flag, and the frame-close test.
  always_comb begin
    accept   = (state_q == ACCUM) && in_valid;
    mismatch = (sym_par != in_par);
    sym_next = sym_cnt_q + 8'd1;
    at_len   = (sym_next == LEN_FULL);
    close    = accept && (in_last || at_len);
    err_inc  = CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
    tot_inc  = CNT_W'(sat_inc(32'(tot_err_q), CNT_MAX));
    par_acc  = frame_par_q ^ sym_par;
    err_acc  = mismatch ? err_inc : err_cnt_q;
  end

  // Next-state and datapath: accumulate while in ACCUM, latch the summary on
  // close including the closing symbol, and clear the frame state once the
  // consumer has taken the summary. tot_err_cnt is never cleared here.
  always_comb begin
    state_d         = state_q;
    frame_par_d     = frame_par_q;
    err_cnt_d       = err_cnt_q;
    sym_cnt_d       = sym_cnt_q;
    tot_err_d       = tot_err_q;
    out_err_cnt_d   = out_err_cnt_q;
    out_frame_par_d = out_frame_par_q;
    out_len_err_d   = out_len_err_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          frame_par_d = par_acc;
          err_cnt_d   = err_acc;
          sym_cnt_d   = sym_next;
          if (mismatch) begin
            tot_err_d = tot_inc;
          end
          if (close) begin
            out_err_cnt_d   = err_acc;
            out_frame_par_d = par_acc;
            // A close without in_last only happens at the full length, so it
            // is always an overlong frame; with in_last it is short unless
            // the count matches exactly.
            out_len_err_d   = in_last ? !at_len : 1'b1;
            state_d         = REPORT;
          end
        end
      end
      REPORT: begin
        if (out_ready) begin
          frame_par_d     = 1'b0;
          err_cnt_d       = '0;
          sym_cnt_d       = 8'd0;
          out_err_cnt_d   = '0;
          out_frame_par_d = 1'b0;
          out_len_err_d   = 1'b0;
          state_d         = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ACCUM;
      frame_par_q     <= 1'b0;
      err_cnt_q       <= '0;
      sym_cnt_q       <= 8'd0;
      tot_err_q       <= '0;
      out_err_cnt_q   <= '0;
      out_frame_par_q <= 1'b0;
      out_len_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_par_q     <= frame_par_d;
      err_cnt_q       <= err_cnt_d;
      sym_cnt_q       <= sym_cnt_d;
      tot_err_q       <= tot_err_d;
      out_err_cnt_q   <= out_err_cnt_d;
      out_frame_par_q <= out_frame_par_d;
      out_len_err_q   <= out_len_err_d;
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready      = (state_q == ACCUM);
  assign out_valid     = (state_q == REPORT);
  assign out_err_cnt   = out_err_cnt_q;
  assign out_frame_par = out_frame_par_q;
  assign out_len_err   = out_len_err_q;
  assign tot_err_cnt   = tot_err_q;

endmodule

// File: tb/tb_xor5_frame_checker.sv
// Directed testbench for xor5_frame_checker. A second instance with 3-bit
// counters shares the same stimulus and is used to observe saturation.
module tb_xor5_frame_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_par;
  logic       in_last;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_err_cnt;
  logic       out_frame_par;
  logic       out_len_err;
  logic [7:0] tot_err_cnt;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [2:0] sat_out_err_cnt;
  logic       sat_out_frame_par;
  logic       sat_out_len_err;
  logic [2:0] sat_tot_err_cnt;

  int checkCount = 0;
  int failCount  = 0;

  // Clean frame: symbols and their hand-computed parities.
  logic [4:0] symTab [8] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111,
                             5'b11111, 5'b00000, 5'b10101, 5'b11000};
  logic       parTab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  xor5_frame_checker #(.FRAME_LEN(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_par        (in_par),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_err_cnt   (out_err_cnt),
    .out_frame_par (out_frame_par),
    .out_len_err   (out_len_err),
    .tot_err_cnt   (tot_err_cnt)
  );

  xor5_frame_checker #(.FRAME_LEN(8), .CNT_W(3)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (sat_in_ready),
    .in_data       (in_data),
    .in_par        (in_par),
    .in_last       (in_last),
    .out_valid     (sat_out_valid),
    .out_ready     (out_ready),
    .out_err_cnt   (sat_out_err_cnt),
    .out_frame_par (sat_out_frame_par),
    .out_len_err   (sat_out_len_err),
    .tot_err_cnt   (sat_tot_err_cnt)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below stalls somewhere unexpected.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one symbol and hold it until the main instance accepts it;
  // returns 1 ns after the accepting edge with in_valid dropped.
  task automatic applyStimulus(input logic [4:0] d, input logic p, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Let a pending summary be consumed (out_ready must already be high).
  task automatic drainSummary();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 5'd0;
    in_par    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_err_cnt", 32'(out_err_cnt), 32'd0);
    checkOutput("rst_frame_par", 32'(out_frame_par), 32'd0);
    checkOutput("rst_len_err", 32'(out_len_err), 32'd0);
    checkOutput("rst_tot", 32'(tot_err_cnt), 32'd0);

    // Clean full frame; four odd-weight symbols give even frame parity.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(symTab[i], parTab[i], i == 7);
      if (i == 6) checkOutput("clean_valid_early", 32'(out_valid), 32'd0);
    end
    checkOutput("clean_valid", 32'(out_valid), 32'd1);
    checkOutput("clean_err_cnt", 32'(out_err_cnt), 32'd0);
    checkOutput("clean_frame_par", 32'(out_frame_par), 32'd0);
    checkOutput("clean_len_err", 32'(out_len_err), 32'd0);
    checkOutput("clean_tot", 32'(tot_err_cnt), 32'd0);

    // Same frame twice with wrong parity on symbols 2 and 5.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        applyStimulus(symTab[i], parTab[i] ^ ((i == 1) || (i == 4)), i == 7);
        if (f == 0 && i == 1) checkOutput("bad_tot_early", 32'(tot_err_cnt), 32'd1);
      end
      checkOutput("bad_valid", 32'(out_valid), 32'd1);
      checkOutput("bad_err_cnt", 32'(out_err_cnt), 32'd2);
      checkOutput("bad_frame_par", 32'(out_frame_par), 32'd0);
      checkOutput("bad_tot", 32'(tot_err_cnt), (f == 0) ? 32'd2 : 32'd4);
    end
    drainSummary();

    // Short frame of 3 (one mismatch), then a stalled consumer while the
    // sender keeps a mismatching symbol on the bus.
    out_ready = 1'b0;
    applyStimulus(5'b00001, 1'b1, 1'b0);
    applyStimulus(5'b00011, 1'b1, 1'b0);
    applyStimulus(5'b00111, 1'b1, 1'b1);
    checkOutput("short_valid", 32'(out_valid), 32'd1);
    checkOutput("short_len_err", 32'(out_len_err), 32'd1);
    checkOutput("short_err_cnt", 32'(out_err_cnt), 32'd1);
    checkOutput("short_frame_par", 32'(out_frame_par), 32'd0);
    checkOutput("short_tot", 32'(tot_err_cnt), 32'd5);
    in_valid = 1'b1;
    in_data  = 5'b11111;
    in_par   = 1'b0;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_err_cnt", 32'(out_err_cnt), 32'd1);
      checkOutput("stall_len_err", 32'(out_len_err), 32'd1);
      checkOutput("stall_tot", 32'(tot_err_cnt), 32'd5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_err_cnt", 32'(out_err_cnt), 32'd0);

    // Ten clean symbols with in_last only on the tenth.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(symTab[i % 8], parTab[i % 8], i == 9);
      if (i == 7) begin
        checkOutput("long_valid", 32'(out_valid), 32'd1);
        checkOutput("long_len_err", 32'(out_len_err), 32'd1);
        checkOutput("long_err_cnt", 32'(out_err_cnt), 32'd0);
        checkOutput("long_frame_par", 32'(out_frame_par), 32'd0);
      end
    end
    checkOutput("tail_valid", 32'(out_valid), 32'd1);
    checkOutput("tail_len_err", 32'(out_len_err), 32'd1);
    checkOutput("tail_frame_par", 32'(out_frame_par), 32'd1);
    checkOutput("tail_err_cnt", 32'(out_err_cnt), 32'd0);
    checkOutput("tail_tot", 32'(tot_err_cnt), 32'd5);
    drainSummary();

    // Reset in the middle of a frame discards it and the running total.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(symTab[i], ~parTab[i], 1'b0);
    end
    checkOutput("pre_rst_tot", 32'(tot_err_cnt), 32'd9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_tot", 32'(tot_err_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(symTab[i], parTab[i], i == 7);
    end
    checkOutput("after_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("after_rst_err_cnt", 32'(out_err_cnt), 32'd0);
    checkOutput("after_rst_len_err", 32'(out_len_err), 32'd0);
    checkOutput("after_rst_tot", 32'(tot_err_cnt), 32'd0);
    drainSummary();

    // Ten mismatching symbols: 3-bit counters pin at 7, 8-bit ones do not.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'b00001, 1'b0, i == 9);
      if (i == 7) begin
        checkOutput("sat_frame_err", 32'(sat_out_err_cnt), 32'd7);
        checkOutput("wide_frame_err", 32'(out_err_cnt), 32'd8);
        checkOutput("sat_len_err", 32'(sat_out_len_err), 32'd1);
        checkOutput("sat_tot_mid", 32'(sat_tot_err_cnt), 32'd7);
      end
    end
    checkOutput("sat_tot", 32'(sat_tot_err_cnt), 32'd7);
    checkOutput("wide_tot", 32'(tot_err_cnt), 32'd10);
    checkOutput("sat_tail_err", 32'(sat_out_err_cnt), 32'd2);
    drainSummary();

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
